// File: rtl/final_judge_if.sv
// Referee-side I/O bundle for final_judge: raw buttons in, scores and status out.
// The bench or board glue drives the master side; final_judge takes the slave side.
interface final_judge_if;
  logic       START;
  logic       KEY1;
  logic       KEY2;
  logic       winner;
  logic       GAME_OVER;
  logic       GO_LED;
  logic [3:0] SCORE1;
  logic [3:0] SCORE2;
  logic       ROUND_P;

  modport master (
    output START, KEY1, KEY2,
    input  winner, GAME_OVER, GO_LED, SCORE1, SCORE2, ROUND_P
  );

  modport slave (
    input  START, KEY1, KEY2,
    output winner, GAME_OVER, GO_LED, SCORE1, SCORE2, ROUND_P
  );
endinterface

// File: rtl/final_judge.sv
// Two-player reaction-game referee: countdown, GO, scoring and game-over detection.
// Define FALSE_START_EN to penalise key presses made during the countdown.
module final_judge #(
  parameter int unsigned WIN_SCORE    = 3,
  parameter int unsigned COUNT_CYCLES = 1000,
  parameter int unsigned HOLD_CYCLES  = 500
) (
  input  logic           CLK,
  input  logic           RESETN,
  final_judge_if.slave   io_bus
);

  typedef enum logic [2:0] {StIdle, StCd, StGo, StHold, StOver} state_e;

  localparam logic [3:0]  WinScore  = 4'(WIN_SCORE);
  localparam logic [15:0] CountLast = 16'(COUNT_CYCLES - 1);
  localparam logic [15:0] HoldLast  = 16'(HOLD_CYCLES - 1);

  // Bit order for the conditioning pipes: {KEY2, KEY1, START}
  logic [2:0]  w_raw, w_evt;
  logic [2:0]  r_sync1, r_sync2, r_prev;
  logic        w_start_ev, w_key1_ev, w_key2_ev;

  state_e      r_state, w_state_d;
  logic [15:0] r_cnt, w_cnt_d;
  logic [3:0]  r_score1, w_score1_d;
  logic [3:0]  r_score2, w_score2_d;
  logic        r_winner, w_winner_d;
  logic        r_round_p, w_round_p_d;
  logic        w_restart;

  assign w_raw      = {io_bus.KEY2, io_bus.KEY1, io_bus.START};
  assign w_evt      = r_sync2 & ~r_prev;
  assign w_start_ev = w_evt[0];
  assign w_key1_ev  = w_evt[1];
  assign w_key2_ev  = w_evt[2];

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      r_sync1   <= '0;
      r_sync2   <= '0;
      r_prev    <= '0;
      r_state   <= StIdle;
      r_cnt     <= '0;
      r_score1  <= '0;
      r_score2  <= '0;
      r_winner  <= 1'b0;
      r_round_p <= 1'b0;
    end else begin
      r_sync1   <= w_raw;
      r_sync2   <= r_sync1;
      r_prev    <= r_sync2;
      r_state   <= w_state_d;
      r_cnt     <= w_cnt_d;
      r_score1  <= w_score1_d;
      r_score2  <= w_score2_d;
      r_winner  <= w_winner_d;
      r_round_p <= w_round_p_d;
    end
  end

  always_comb begin
    w_state_d   = r_state;
    w_score1_d  = r_score1;
    w_score2_d  = r_score2;
    w_winner_d  = r_winner;
    w_round_p_d = 1'b0;
    w_restart   = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (w_start_ev) begin
          w_score1_d = '0;
          w_score2_d = '0;
          w_state_d  = StCd;
        end
      end
      StCd: begin
`ifdef FALSE_START_EN
        // A false start hands the point to the opponent; a double false start reruns the count
        if (w_key1_ev && w_key2_ev) begin
          w_restart = 1'b1;
        end else if (w_key1_ev) begin
          w_score2_d  = r_score2 + 4'd1;
          w_round_p_d = 1'b1;
          w_state_d   = StHold;
        end else if (w_key2_ev) begin
          w_score1_d  = r_score1 + 4'd1;
          w_round_p_d = 1'b1;
          w_state_d   = StHold;
        end else if (r_cnt == CountLast) begin
          w_state_d = StGo;
        end
`else
        if (r_cnt == CountLast) begin
          w_state_d = StGo;
        end
`endif
      end
      StGo: begin
        if (w_key1_ev || w_key2_ev) begin
          w_round_p_d = 1'b1;
          w_state_d   = StHold;
          if (w_key1_ev && !w_key2_ev) w_score1_d = r_score1 + 4'd1;
          if (w_key2_ev && !w_key1_ev) w_score2_d = r_score2 + 4'd1;
        end
      end
      StHold: begin
        if (r_cnt == HoldLast) begin
          if (r_score1 == WinScore || r_score2 == WinScore) begin
            w_state_d  = StOver;
            w_winner_d = (r_score1 != WinScore);
          end else begin
            w_state_d = StCd;
          end
        end
      end
      StOver: begin
        if (w_start_ev) begin
          w_score1_d = '0;
          w_score2_d = '0;
          w_winner_d = 1'b0;
          w_state_d  = StCd;
        end
      end
      default: w_state_d = StIdle;
    endcase
    // Counter restarts on every state entry
    w_cnt_d = (w_state_d != r_state || w_restart) ? '0 : r_cnt + 16'd1;
  end

  assign io_bus.winner    = r_winner;
  assign io_bus.GAME_OVER = (r_state == StOver);
  assign io_bus.GO_LED    = (r_state == StGo);
  assign io_bus.SCORE1    = r_score1;
  assign io_bus.SCORE2    = r_score2;
  assign io_bus.ROUND_P   = r_round_p;

endmodule
